// File: rtl/conv_index_sched.sv
// Convolution index-buffer scheduler: validates a layer descriptor, loads the buffer controller,
// then issues K*K*C/16 read beats per output pass and waits for every beat to return.
module conv_index_sched #(
  parameter int unsigned Ifm_Width       = 9,
  parameter int unsigned Read_Addr_Width = 11
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cfg_valid,
  output logic                       cfg_ready,
  input  logic [3:0]                 cfg_kernel,
  input  logic [11:0]                cfg_channels,
  input  logic [Ifm_Width-1:0]       cfg_ow,
  input  logic [Ifm_Width-1:0]       cfg_oh14,
  output logic                       value_en,
  output logic [Ifm_Width-1:0]       Addrtimes_end,
  output logic [Read_Addr_Width+4:0] k_k_channels,
  output logic                       sys_start,
  input  logic                       mac_ready,
  output logic                       en_to_fifo,
  input  logic                       rd_valid,
  output logic                       busy,
  output logic                       layer_done,
  output logic                       cfg_err
);

  localparam int unsigned KKC_W  = Read_Addr_Width + 5;
  localparam int unsigned BPP_W  = KKC_W - 4;
  localparam int unsigned PROD_W = 20;
  localparam int unsigned AREA_W = 2 * Ifm_Width;
  localparam int unsigned CNT_W  = 21;

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_LOAD, S_START, S_RUN, S_DRAIN, S_DONE
  } state_t;

  state_t state, state_n;

  logic [3:0]           kernel_q;
  logic [11:0]          channels_q;
  logic [Ifm_Width-1:0] ow_q, oh14_q;
  logic [PROD_W-1:0]    kkc_full;
  logic [AREA_W-1:0]    area_full;
  logic                 reject;
  logic [BPP_W-1:0]     bpp, beat;
  logic [Ifm_Width-1:0] pass;
  logic [CNT_W-1:0]     total, issued, returned;
  logic                 last_beat, last_pass, issue_last;

  // Full-precision descriptor products, checked before anything is truncated
  assign kkc_full  = PROD_W'(kernel_q) * PROD_W'(kernel_q) * PROD_W'(channels_q);
  assign area_full = AREA_W'(ow_q) * AREA_W'(oh14_q);
  assign reject    = (kkc_full == '0) || (|(kkc_full >> KKC_W)) || (kkc_full[3:0] != 4'd0) ||
                     (area_full == '0) || (|(area_full >> Ifm_Width));

  assign bpp        = k_k_channels[KKC_W-1:4];
  assign total      = CNT_W'(bpp) * CNT_W'(Addrtimes_end);
  assign last_beat  = (beat == bpp - BPP_W'(1));
  assign last_pass  = (pass == Addrtimes_end - Ifm_Width'(1));
  assign issue_last = (issued == total - CNT_W'(1));

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n    = state;
    en_to_fifo = 1'b0;
    unique case (state)
      S_IDLE:  if (cfg_valid) state_n = S_CHECK;
      S_CHECK: state_n = reject ? S_IDLE : S_LOAD;
      S_LOAD:  state_n = S_START;
      S_START: state_n = S_RUN;
      S_RUN: begin
        if (issued < total) begin
          en_to_fifo = mac_ready;
          if (mac_ready && issue_last) state_n = S_DRAIN;
        end
      end
      S_DRAIN: if (returned == total) state_n = S_DONE;
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Status strobes are registered from the next state so they line up with the state they name
  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_ready     <= 1'b1;
      value_en      <= 1'b0;
      sys_start     <= 1'b0;
      busy          <= 1'b0;
      layer_done    <= 1'b0;
      cfg_err       <= 1'b0;
      k_k_channels  <= '0;
      Addrtimes_end <= '0;
      kernel_q      <= '0;
      channels_q    <= '0;
      ow_q          <= '0;
      oh14_q        <= '0;
      beat          <= '0;
      pass          <= '0;
      issued        <= '0;
      returned      <= '0;
    end else begin
      cfg_ready  <= (state_n == S_IDLE);
      value_en   <= (state_n == S_LOAD);
      sys_start  <= (state_n == S_START);
      busy       <= (state_n != S_IDLE);
      layer_done <= (state_n == S_DONE);
      cfg_err    <= (state == S_CHECK) && reject;

      if (state == S_IDLE && cfg_valid) begin
        kernel_q   <= cfg_kernel;
        channels_q <= cfg_channels;
        ow_q       <= cfg_ow;
        oh14_q     <= cfg_oh14;
      end

      if (state == S_CHECK && !reject) begin
        k_k_channels  <= KKC_W'(kkc_full);
        Addrtimes_end <= Ifm_Width'(area_full);
      end

      if (state_n == S_LOAD) begin
        beat     <= '0;
        pass     <= '0;
        issued   <= '0;
        returned <= '0;
      end else begin
        // en_to_fifo already implies mac_ready, so a stalled MAC freezes the issue side
        if (en_to_fifo) begin
          issued <= issued + CNT_W'(1);
          if (last_beat) begin
            beat <= '0;
            pass <= last_pass ? '0 : pass + Ifm_Width'(1);
          end else begin
            beat <= beat + BPP_W'(1);
          end
        end
        if (rd_valid && (state == S_RUN || state == S_DRAIN))
          returned <= returned + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_conv_index_sched.sv
// Directed bench for conv_index_sched; a small responder returns each read beat two cycles later.
module tb_conv_index_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_valid, cfg_ready;
  logic [3:0] cfg_kernel;
  logic [11:0] cfg_channels;
  logic [8:0] cfg_ow, cfg_oh14;
  logic       value_en;
  logic [8:0] Addrtimes_end;
  logic [15:0] k_k_channels;
  logic       sys_start, mac_ready, en_to_fifo, rd_valid, busy, layer_done, cfg_err;

  conv_index_sched dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_kernel(cfg_kernel), .cfg_channels(cfg_channels),
    .cfg_ow(cfg_ow), .cfg_oh14(cfg_oh14),
    .value_en(value_en), .Addrtimes_end(Addrtimes_end), .k_k_channels(k_k_channels),
    .sys_start(sys_start), .mac_ready(mac_ready), .en_to_fifo(en_to_fifo),
    .rd_valid(rd_valid), .busy(busy), .layer_done(layer_done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_errors = 0;
  int cyc = 0;
  int n_en, n_en_low, n_rd, n_ve, n_ss, n_err, n_done, n_hs;
  int rd_at_done, first_done_cyc, hs_cyc;
  logic [1:0] rd_pipe;
  logic hs_pending, hold_next, mr_toggle;
  logic [3:0] k2;
  logic [11:0] c2;
  logic [8:0] ow2, oh2;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_counts();
    n_en = 0; n_en_low = 0; n_rd = 0; n_ve = 0; n_ss = 0; n_err = 0; n_done = 0; n_hs = 0;
    rd_at_done = -1; first_done_cyc = -1; hs_cyc = -1;
  endtask

  // One clock: entered and left at a negedge; observes outputs 1ns after driving inputs
  task automatic step();
    if (hs_pending) begin
      hs_pending = 1'b0;
      if (hold_next) begin
        hold_next = 1'b0;
        cfg_kernel = k2; cfg_channels = c2; cfg_ow = ow2; cfg_oh14 = oh2;
      end else begin
        cfg_valid = 1'b0;
      end
    end
    mac_ready = mr_toggle ? ((cyc % 2) == 0) : 1'b1;
    rd_valid  = rd_pipe[1];
    #1;
    if (rd_valid) n_rd++;
    if (en_to_fifo) begin
      n_en++;
      if (!mac_ready) n_en_low++;
    end
    if (value_en)  n_ve++;
    if (sys_start) n_ss++;
    if (cfg_err)   n_err++;
    if (layer_done) begin
      n_done++;
      rd_at_done = n_rd;
      if (n_done == 1) first_done_cyc = cyc;
    end
    if (cfg_valid && cfg_ready) begin
      n_hs++;
      hs_cyc = cyc;
      hs_pending = 1'b1;
    end
    rd_pipe = {rd_pipe[0], en_to_fifo};
    cyc++;
    @(negedge clk);
  endtask

  task automatic set_desc(input logic [3:0] k, input logic [11:0] c, input logic [8:0] ow,
                          input logic [8:0] oh);
    cfg_kernel = k; cfg_channels = c; cfg_ow = ow; cfg_oh14 = oh;
    cfg_valid = 1'b1;
  endtask

  task automatic run_until_done(input string tag, input int target, input int budget);
    int start;
    start = cyc;
    while (n_done < target && (cyc - start) < budget) step();
    repeat (4) step();
    check_eq(tag, n_done, target);
  endtask

  initial begin
    rst = 1'b1; cfg_valid = 1'b0; cfg_kernel = '0; cfg_channels = '0; cfg_ow = '0; cfg_oh14 = '0;
    mac_ready = 1'b1; rd_valid = 1'b0; rd_pipe = '0;
    hs_pending = 1'b0; hold_next = 1'b0; mr_toggle = 1'b0;
    k2 = '0; c2 = '0; ow2 = '0; oh2 = '0;
    clear_counts();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("rst_cfg_ready", cfg_ready, 1);
    check_eq("rst_value_en", value_en, 0);
    check_eq("rst_sys_start", sys_start, 0);
    check_eq("rst_en_to_fifo", en_to_fifo, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_layer_done", layer_done, 0);
    check_eq("rst_cfg_err", cfg_err, 0);
    check_eq("rst_kkc", k_k_channels, 0);
    check_eq("rst_addrtimes", Addrtimes_end, 0);
    @(negedge clk);

    // Basic layer: 3*3*32 = 288 -> 18 beats/pass, 4*1 passes, 72 beats
    clear_counts();
    set_desc(4'd3, 12'd32, 9'd4, 9'd1);
    run_until_done("l1_done", 1, 300);
    check_eq("l1_kkc", k_k_channels, 288);
    check_eq("l1_addrtimes", Addrtimes_end, 4);
    check_eq("l1_beats", n_en, 72);
    check_eq("l1_rd_at_done", rd_at_done, 72);
    check_eq("l1_value_en", n_ve, 1);
    check_eq("l1_sys_start", n_ss, 1);
    check_eq("l1_cfg_err", n_err, 0);
    check_eq("l1_busy_after", busy, 0);
    check_eq("l1_ready_after", cfg_ready, 1);

    // Same layer with mac_ready stalling every other cycle
    clear_counts();
    mr_toggle = 1'b1;
    set_desc(4'd3, 12'd32, 9'd4, 9'd1);
    run_until_done("tog_done", 1, 400);
    mr_toggle = 1'b0;
    check_eq("tog_beats", n_en, 72);
    check_eq("tog_en_while_stalled", n_en_low, 0);
    check_eq("tog_rd_at_done", rd_at_done, 72);

    // 3*3*8 = 72 is not a multiple of 16
    clear_counts();
    set_desc(4'd3, 12'd8, 9'd4, 9'd1);
    repeat (6) step();
    check_eq("mod16_cfg_err", n_err, 1);
    check_eq("mod16_value_en", n_ve, 0);
    check_eq("mod16_sys_start", n_ss, 0);
    check_eq("mod16_ready", cfg_ready, 1);
    check_eq("mod16_busy", busy, 0);
    check_eq("mod16_kkc_held", k_k_channels, 288);

    // 40*13 = 520 overflows 9 bits
    clear_counts();
    set_desc(4'd3, 12'd32, 9'd40, 9'd13);
    repeat (6) step();
    check_eq("area_ovf_cfg_err", n_err, 1);
    check_eq("area_ovf_value_en", n_ve, 0);
    check_eq("area_ovf_addrtimes_held", Addrtimes_end, 4);

    // Zero output width
    clear_counts();
    set_desc(4'd3, 12'd32, 9'd0, 9'd1);
    repeat (6) step();
    check_eq("ow0_cfg_err", n_err, 1);
    check_eq("ow0_beats", n_en, 0);

    // Reset mid-RUN after 10 beats
    clear_counts();
    set_desc(4'd3, 12'd32, 9'd4, 9'd1);
    while (n_en < 10 && n_done == 0 && cyc < 20000) step();
    check_eq("mid_beats_before_rst", n_en, 10);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    check_eq("mid_rst_en_to_fifo", en_to_fifo, 0);
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_ready", cfg_ready, 1);
    check_eq("mid_rst_kkc", k_k_channels, 0);
    @(negedge clk);
    rd_pipe = '0;
    clear_counts();
    set_desc(4'd3, 12'd32, 9'd4, 9'd1);
    run_until_done("after_rst_done", 1, 300);
    check_eq("after_rst_beats", n_en, 72);
    check_eq("after_rst_value_en", n_ve, 1);

    // Back-to-back: cfg_valid held, second descriptor is 3*3*32 with ow=2 (36 beats)
    clear_counts();
    k2 = 4'd3; c2 = 12'd32; ow2 = 9'd2; oh2 = 9'd1;
    hold_next = 1'b1;
    set_desc(4'd3, 12'd32, 9'd4, 9'd1);
    run_until_done("b2b_done", 2, 500);
    check_eq("b2b_handshakes", n_hs, 2);
    check_eq("b2b_second_after_done", (hs_cyc > first_done_cyc), 1);
    check_eq("b2b_value_en", n_ve, 2);
    check_eq("b2b_sys_start", n_ss, 2);
    check_eq("b2b_beats", n_en, 108);
    check_eq("b2b_addrtimes", Addrtimes_end, 2);
    check_eq("b2b_valid_dropped", cfg_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
